// File: rtl/bep_manchester_tx.sv
// BEP thermostat link transmitter: serialises one 160-bit frame MSB first,
// Manchester-encoded, then holds a forced-low gap before pulsing done.
module bep_manchester_tx #(
   parameter int HALF_BIT_CYCLES = 8,
   parameter int GAP_HALF_BITS   = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] thermostat_id,
   input  logic [15:0] room_temp,
   input  logic [15:0] set_temp,
   input  logic [7:0]  state,
   output logic        busy,
   output logic        tx_active,
   output logic        tx_out,
   output logic        done
);

   localparam int GAP_CYCLES = GAP_HALF_BITS * HALF_BIT_CYCLES;
   localparam int HALF_W     = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
   localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_BIT_CYCLES - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
   localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
   localparam logic [HALF_W-1:0] HALF_ONE  = HALF_W'(1);

   localparam logic [31:0] PREAMBLE   = 32'hAAAAAAAA;
   localparam logic [15:0] FRAME_TYPE = 16'hD391;
   localparam logic [31:0] TRAILER    = 32'h0DFFFFFE;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_GAP
   } fsm_state_t;

   fsm_state_t        fsm_state;
   logic [159:0]      shift_reg;
   logic [HALF_W-1:0] half_cnt;
   logic              phase;
   logic [7:0]        bit_cnt;
   logic [GAP_W-1:0]  gap_cnt;

   logic [7:0]        checksum;
   logic [159:0]      frame_word;

   // Checksum is taken straight from the inputs so the accept cycle can load a complete frame.
   always_comb begin
      checksum = thermostat_id[31:24] + thermostat_id[23:16]
               + thermostat_id[15:8]  + thermostat_id[7:0]
               + room_temp[15:8]      + room_temp[7:0]
               + set_temp[15:8]       + set_temp[7:0]
               + state;
      frame_word = {PREAMBLE, FRAME_TYPE, thermostat_id, room_temp,
                    set_temp, state, TRAILER, checksum};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm_state <= ST_IDLE;
         shift_reg <= '0;
         half_cnt  <= '0;
         phase     <= 1'b0;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
         busy      <= 1'b0;
         tx_active <= 1'b0;
         tx_out    <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (fsm_state)
            ST_IDLE: begin
               tx_out    <= 1'b0;
               tx_active <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b0;
               if (start) begin
                  fsm_state <= ST_SEND;
                  shift_reg <= frame_word;
                  half_cnt  <= '0;
                  phase     <= 1'b0;
                  bit_cnt   <= 8'd159;
                  busy      <= 1'b1;
                  tx_active <= 1'b1;
                  tx_out    <= frame_word[159];
               end
            end

            // The current bit always sits at shift_reg[159]; tx_out is set one edge ahead of each half.
            ST_SEND: begin
               if (half_cnt == HALF_LAST) begin
                  half_cnt <= '0;
                  if (!phase) begin
                     phase  <= 1'b1;
                     tx_out <= ~shift_reg[159];
                  end else if (bit_cnt == 8'd0) begin
                     fsm_state <= ST_GAP;
                     phase     <= 1'b0;
                     tx_out    <= 1'b0;
                     tx_active <= 1'b0;
                     gap_cnt   <= '0;
                     done      <= (GAP_LAST == '0);
                  end else begin
                     phase     <= 1'b0;
                     bit_cnt   <= bit_cnt - 8'd1;
                     shift_reg <= {shift_reg[158:0], 1'b0};
                     tx_out    <= shift_reg[158];
                  end
               end else begin
                  half_cnt <= half_cnt + HALF_ONE;
               end
            end

            ST_GAP: begin
               tx_out    <= 1'b0;
               tx_active <= 1'b0;
               if (gap_cnt == GAP_LAST) begin
                  fsm_state <= ST_IDLE;
                  gap_cnt   <= '0;
                  busy      <= 1'b0;
                  done      <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt + GAP_ONE;
                  done    <= ((gap_cnt + GAP_ONE) == GAP_LAST);
               end
            end

            default: begin
               fsm_state <= ST_IDLE;
               busy      <= 1'b0;
               tx_active <= 1'b0;
               tx_out    <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bep_manchester_tx.sv
// Directed bench for bep_manchester_tx: decodes the Manchester line and checks
// frame contents, timing of tx_active/busy/done, ignored starts, abort and back-to-back.
module tb_bep_manchester_tx;

   localparam int H         = 2;
   localparam int G         = 4;
   localparam int FRAME_CYC = 320 * H;
   localparam int BUSY_CYC  = FRAME_CYC + G * H;
   localparam int CAP       = 700;
   localparam int BCAP      = 650;

   localparam logic [159:0] GOLDEN = {32'hAAAAAAAA, 16'hD391, 32'h01020304, 16'h00E6,
                                      16'h00D2, 8'h01, 32'h0DFFFFFE, 8'hC3};
   localparam logic [159:0] WRAP   = {32'hAAAAAAAA, 16'hD391, 32'hFFFFFFFF, 16'hFFFF,
                                      16'hFFFF, 8'hFF, 32'h0DFFFFFE, 8'hF7};

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        start_b;
   logic [31:0] thermostat_id;
   logic [15:0] room_temp;
   logic [15:0] set_temp;
   logic [7:0]  state;
   logic        busy, tx_active, tx_out, done;
   logic        busy_b, tx_active_b, tx_out_b, done_b;

   int errors = 0;
   int checks = 0;

   logic cap_line [CAP];
   logic cap_act  [CAP];
   logic cap_busy [CAP];
   logic cap_done [CAP];
   logic b_line   [BCAP];
   logic b_busy   [BCAP];
   logic b_done   [BCAP];

   always #5 clk = ~clk;

   bep_manchester_tx #(.HALF_BIT_CYCLES(H), .GAP_HALF_BITS(G)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .thermostat_id(thermostat_id), .room_temp(room_temp),
      .set_temp(set_temp), .state(state),
      .busy(busy), .tx_active(tx_active), .tx_out(tx_out), .done(done)
   );

   bep_manchester_tx #(.HALF_BIT_CYCLES(1), .GAP_HALF_BITS(G)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b),
      .thermostat_id(thermostat_id), .room_temp(room_temp),
      .set_temp(set_temp), .state(state),
      .busy(busy_b), .tx_active(tx_active_b), .tx_out(tx_out_b), .done(done_b)
   );

   function automatic logic line_at(input bit from_b, input int idx);
      return from_b ? b_line[idx] : cap_line[idx];
   endfunction

   // A bit's value is the level of its first half.
   function automatic logic [159:0] decode_bits(input int base, input int h, input bit from_b);
      logic [159:0] r;
      r = '0;
      for (int k = 0; k < 160; k++) r[159-k] = line_at(from_b, base + 2*h*k);
      return r;
   endfunction

   function automatic int manchester_errors(input int base, input int h, input bit from_b);
      int   n;
      logic first, v;
      n = 0;
      for (int k = 0; k < 160; k++) begin
         first = line_at(from_b, base + 2*h*k);
         for (int j = 0; j < 2*h; j++) begin
            v = line_at(from_b, base + 2*h*k + j);
            if (j < h) begin
               if (v !== first) n++;
            end else begin
               if (v !== ~first) n++;
            end
         end
      end
      return n;
   endfunction

   function automatic int shape_errors();
      int n;
      n = 0;
      for (int c = 0; c < CAP; c++) begin
         if (cap_act[c]  !== (c < FRAME_CYC))     n++;
         if (cap_busy[c] !== (c < BUSY_CYC))      n++;
         if (cap_done[c] !== (c == BUSY_CYC - 1)) n++;
         if (c >= FRAME_CYC && cap_line[c] !== 1'b0) n++;
      end
      return n;
   endfunction

   function automatic int count_ones(input int which);
      int n;
      n = 0;
      for (int c = 0; c < CAP; c++) begin
         if (which == 0 && cap_act[c]  === 1'b1) n++;
         if (which == 1 && cap_busy[c] === 1'b1) n++;
         if (which == 2 && cap_done[c] === 1'b1) n++;
      end
      return n;
   endfunction

   task automatic applyStimulus(input logic [31:0] id, input logic [15:0] room,
                                input logic [15:0] setp, input logic [7:0] st);
      thermostat_id = id;
      room_temp     = room;
      set_temp      = setp;
      state         = st;
   endtask

   // Accepts a frame on dut and records CAP cycles starting at the first half of bit 159.
   task automatic send_and_capture(input int inject_at);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < CAP; c++) begin
         cap_line[c] = tx_out;
         cap_act[c]  = tx_active;
         cap_busy[c] = busy;
         cap_done[c] = done;
         if (c == inject_at) begin
            start = 1'b1;
            applyStimulus(32'hDEADBEEF, 16'h1234, 16'h5678, 8'h99);
         end else if (c == inject_at + 1) begin
            start = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      int bad;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({tx_out, busy, tx_active, done, tx_out_b, busy_b, tx_active_b, done_b} !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_state: got %b expected 00000000",
                  {tx_out, busy, tx_active, done, tx_out_b, busy_b, tx_active_b, done_b});
      end
      rst_n = 1'b1;
      bad = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if ({tx_out, busy, tx_active, done, tx_out_b, busy_b, tx_active_b, done_b} !== 8'h00) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL reset_idle: %0d non-idle cycles, expected 0", bad);
      end
   endtask

   task automatic test_golden();
      logic [159:0] got;
      int           n;
      applyStimulus(32'h01020304, 16'h00E6, 16'h00D2, 8'h01);
      send_and_capture(-1);
      got = decode_bits(0, H, 1'b0);
      checks++;
      if (got !== GOLDEN) begin
         errors++;
         $display("[TB] FAIL golden_frame: got %h expected %h", got, GOLDEN);
      end
      checks++;
      if (got[7:0] !== 8'hC3) begin
         errors++;
         $display("[TB] FAIL golden_checksum: got %h expected c3", got[7:0]);
      end
      n = manchester_errors(0, H, 1'b0);
      checks++;
      if (n != 0) begin
         errors++;
         $display("[TB] FAIL golden_manchester: %0d bad half-bit cycles, expected 0", n);
      end
      n = count_ones(0);
      checks++;
      if (n != 640) begin
         errors++;
         $display("[TB] FAIL golden_tx_active_len: got %0d expected 640", n);
      end
      n = count_ones(1);
      checks++;
      if (n != 648) begin
         errors++;
         $display("[TB] FAIL golden_busy_len: got %0d expected 648", n);
      end
      n = shape_errors();
      checks++;
      if (n != 0) begin
         errors++;
         $display("[TB] FAIL golden_timing: %0d cycles off-shape, expected 0", n);
      end
   endtask

   task automatic test_checksum_wrap();
      logic [159:0] got;
      applyStimulus(32'hFFFFFFFF, 16'hFFFF, 16'hFFFF, 8'hFF);
      send_and_capture(-1);
      got = decode_bits(0, H, 1'b0);
      checks++;
      if (got !== WRAP) begin
         errors++;
         $display("[TB] FAIL wrap_frame: got %h expected %h", got, WRAP);
      end
      checks++;
      if (got[7:0] !== 8'hF7) begin
         errors++;
         $display("[TB] FAIL wrap_checksum: got %h expected f7", got[7:0]);
      end
   endtask

   task automatic test_ignored_start();
      logic [159:0] got;
      int           n;
      applyStimulus(32'h01020304, 16'h00E6, 16'h00D2, 8'h01);
      send_and_capture(4 * H * (159 - 100) / 2);
      got = decode_bits(0, H, 1'b0);
      checks++;
      if (got !== GOLDEN) begin
         errors++;
         $display("[TB] FAIL ignored_frame: got %h expected %h", got, GOLDEN);
      end
      n = count_ones(2);
      checks++;
      if (n != 1) begin
         errors++;
         $display("[TB] FAIL ignored_done_count: got %0d expected 1", n);
      end
      n = shape_errors();
      checks++;
      if (n != 0) begin
         errors++;
         $display("[TB] FAIL ignored_timing: %0d cycles off-shape, expected 0", n);
      end
   endtask

   task automatic test_abort();
      logic [159:0] got;
      int           n;
      applyStimulus(32'h01020304, 16'h00E6, 16'h00D2, 8'h01);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2 * H * (159 - 50)) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({tx_out, busy, tx_active, done} !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL abort_state: got %b expected 0000", {tx_out, busy, tx_active, done});
      end
      rst_n = 1'b1;
      n = 0;
      for (int c = 0; c < CAP; c++) begin
         if (done === 1'b1 || busy === 1'b1) n++;
         @(negedge clk);
      end
      checks++;
      if (n != 0) begin
         errors++;
         $display("[TB] FAIL abort_no_done: %0d busy/done cycles, expected 0", n);
      end
      send_and_capture(-1);
      got = decode_bits(0, H, 1'b0);
      checks++;
      if (got !== GOLDEN) begin
         errors++;
         $display("[TB] FAIL abort_refresh_frame: got %h expected %h", got, GOLDEN);
      end
   endtask

   task automatic test_back_to_back();
      logic [159:0] f1, f2;
      int           first_done;
      applyStimulus(32'h01020304, 16'h00E6, 16'h00D2, 8'h01);
      start_b = 1'b1;
      @(negedge clk);
      for (int c = 0; c < BCAP - 1; c++) begin
         b_line[c] = tx_out_b;
         b_busy[c] = busy_b;
         b_done[c] = done_b;
         if (c == BCAP - 2) start_b = 1'b0;
         @(negedge clk);
      end
      first_done = -1;
      for (int c = BCAP - 2; c >= 0; c--) if (b_done[c] === 1'b1) first_done = c;
      checks++;
      if (first_done != 323) begin
         errors++;
         $display("[TB] FAIL b2b_first_done: got cycle %0d expected 323", first_done);
      end
      checks++;
      if ({b_busy[324], b_busy[325]} !== 2'b01) begin
         errors++;
         $display("[TB] FAIL b2b_idle_gap: busy got %b expected 01", {b_busy[324], b_busy[325]});
      end
      checks++;
      if (b_done[648] !== 1'b1) begin
         errors++;
         $display("[TB] FAIL b2b_second_done: got %b expected 1", b_done[648]);
      end
      f1 = decode_bits(0, 1, 1'b1);
      f2 = decode_bits(325, 1, 1'b1);
      checks++;
      if (f1 !== GOLDEN) begin
         errors++;
         $display("[TB] FAIL b2b_frame1: got %h expected %h", f1, GOLDEN);
      end
      checks++;
      if (f2 !== GOLDEN) begin
         errors++;
         $display("[TB] FAIL b2b_frame2: got %h expected %h", f2, GOLDEN);
      end
      checks++;
      if (manchester_errors(0, 1, 1'b1) + manchester_errors(325, 1, 1'b1) != 0) begin
         errors++;
         $display("[TB] FAIL b2b_manchester: got %0d bad cycles expected 0",
                  manchester_errors(0, 1, 1'b1) + manchester_errors(325, 1, 1'b1));
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      start_b = 1'b0;
      applyStimulus(32'h0, 16'h0, 16'h0, 8'h0);
      test_reset();
      test_golden();
      test_checksum_wrap();
      test_ignored_start();
      test_abort();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
